// File: rtl/raw_split_5_streams.sv
// Re-serialises the 80-bit combined 5-lane word into one 16-bit sample per cycle, tagged with
// one-hot lane and absolute channel. Define RAW_SPLIT_FRAME_CNT_EN to build the frame counter.
module raw_split_5_streams #(
    parameter int unsigned NUM_STREAMS   = 5,
    parameter int unsigned CH_PER_STREAM = 32,
    parameter int unsigned DW            = 16
) (
    input  logic                      bus_clk,
    input  logic                      aresetn,
    input  logic                      s_axis_tvalid,
    output logic                      s_axis_tready,
    input  logic [NUM_STREAMS*DW-1:0] s_axis_tdata,
    output logic                      m_axis_tvalid,
    input  logic                      m_axis_tready,
    output logic [DW-1:0]             m_axis_tdata,
    output logic [NUM_STREAMS-1:0]    m_axis_tstreamno,
    output logic [7:0]                m_axis_tchno,
    output logic                      m_axis_tlast,
    output logic [31:0]               frame_cnt
);

    localparam int unsigned LW = $clog2(NUM_STREAMS);
    localparam int unsigned CW = $clog2(CH_PER_STREAM);
    localparam logic [LW-1:0] LastLane = LW'(NUM_STREAMS - 1);
    localparam logic [CW-1:0] LastCh   = CW'(CH_PER_STREAM - 1);

    typedef enum logic [0:0] {StEmpty, StEmit} state_e;

    typedef struct packed {
        logic [DW-1:0]          data;
        logic [NUM_STREAMS-1:0] streamno;
        logic [7:0]             chno;
        logic                   last;
    } beat_t;

    state_e                    state_q;
    logic [NUM_STREAMS*DW-1:0] word_q;
    logic [LW-1:0]             lane_q;
    logic [CW-1:0]             ch_idx_q;
    logic                      valid_q;
    beat_t                     beat_q;
    logic [CW-1:0]             ch_next;
    logic                      last_lane;

    // Lane 0 sits in the most significant slice of the packed word.
    function automatic beat_t make_beat(input logic [NUM_STREAMS*DW-1:0] w,
                                        input logic [LW-1:0] l, input logic [CW-1:0] c);
        beat_t b;
        b.data = '0;
        for (int i = 0; i < int'(NUM_STREAMS); i++) begin
            if (l == LW'(i)) b.data = w[(NUM_STREAMS - 1 - i) * DW +: DW];
        end
        b.streamno = NUM_STREAMS'(1) << l;
        b.chno     = 8'(32'(l) * CH_PER_STREAM + 32'(c));
        b.last     = (l == LastLane) && (c == LastCh);
        return b;
    endfunction

    assign last_lane = (lane_q == LastLane);
    assign ch_next   = (ch_idx_q == LastCh) ? '0 : ch_idx_q + CW'(1);

    // On the last lane the next word can be taken in the same cycle the final beat leaves.
    assign s_axis_tready = aresetn &&
                           ((state_q == StEmpty) || (last_lane && m_axis_tready));

    always_ff @(posedge bus_clk) begin
        if (!aresetn) begin
            state_q  <= StEmpty;
            word_q   <= '0;
            lane_q   <= '0;
            ch_idx_q <= '0;
            valid_q  <= 1'b0;
            beat_q   <= '0;
        end else begin
            unique case (state_q)
                StEmpty: begin
                    if (s_axis_tvalid) begin
                        word_q  <= s_axis_tdata;
                        lane_q  <= '0;
                        valid_q <= 1'b1;
                        beat_q  <= make_beat(s_axis_tdata, '0, ch_idx_q);
                        state_q <= StEmit;
                    end
                end
                StEmit: begin
                    if (m_axis_tready) begin
                        if (!last_lane) begin
                            lane_q <= lane_q + LW'(1);
                            beat_q <= make_beat(word_q, lane_q + LW'(1), ch_idx_q);
                        end else begin
                            ch_idx_q <= ch_next;
                            lane_q   <= '0;
                            if (s_axis_tvalid) begin
                                word_q <= s_axis_tdata;
                                beat_q <= make_beat(s_axis_tdata, '0, ch_next);
                            end else begin
                                valid_q <= 1'b0;
                                beat_q  <= '0;
                                state_q <= StEmpty;
                            end
                        end
                    end
                end
                default: state_q <= StEmpty;
            endcase
        end
    end

    assign m_axis_tvalid    = valid_q;
    assign m_axis_tdata     = beat_q.data;
    assign m_axis_tstreamno = beat_q.streamno;
    assign m_axis_tchno     = beat_q.chno;
    assign m_axis_tlast     = beat_q.last;

`ifdef RAW_SPLIT_FRAME_CNT_EN
    logic [31:0] frame_cnt_q;

    always_ff @(posedge bus_clk) begin
        if (!aresetn) begin
            frame_cnt_q <= '0;
        end else if (valid_q && m_axis_tready && beat_q.last) begin
            frame_cnt_q <= frame_cnt_q + 32'd1;
        end
    end

    assign frame_cnt = frame_cnt_q;
`else
    assign frame_cnt = 32'h0;
`endif

endmodule

// File: tb/tb_raw_split_5_streams.sv
// Directed bench for raw_split_5_streams: ordering, back-to-back streaming, stalls, input gaps,
// mid-frame reset and the frame counter (expected value follows RAW_SPLIT_FRAME_CNT_EN).
module tb_raw_split_5_streams;

    localparam int NS  = 5;
    localparam int CPS = 32;
    localparam int DW  = 16;

    logic               bus_clk = 1'b0;
    logic               aresetn = 1'b0;
    logic               s_axis_tvalid = 1'b0;
    logic               s_axis_tready;
    logic [NS*DW-1:0]   s_axis_tdata = '0;
    logic               m_axis_tvalid;
    logic               m_axis_tready = 1'b1;
    logic [DW-1:0]      m_axis_tdata;
    logic [NS-1:0]      m_axis_tstreamno;
    logic [7:0]         m_axis_tchno;
    logic               m_axis_tlast;
    logic [31:0]        frame_cnt;

    int n_checks   = 0;
    int n_fail     = 0;
    int exp_ch     = 0;
    int exp_frames = 0;

    raw_split_5_streams dut (
        .bus_clk          (bus_clk),
        .aresetn          (aresetn),
        .s_axis_tvalid    (s_axis_tvalid),
        .s_axis_tready    (s_axis_tready),
        .s_axis_tdata     (s_axis_tdata),
        .m_axis_tvalid    (m_axis_tvalid),
        .m_axis_tready    (m_axis_tready),
        .m_axis_tdata     (m_axis_tdata),
        .m_axis_tstreamno (m_axis_tstreamno),
        .m_axis_tchno     (m_axis_tchno),
        .m_axis_tlast     (m_axis_tlast),
        .frame_cnt        (frame_cnt)
    );

    always #5 bus_clk = ~bus_clk;

    task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    function automatic logic [DW-1:0] sample_of(input int j, input int l);
        return DW'((j << 4) | l);
    endfunction

    // Lane 0 goes to the top slice of the word.
    function automatic logic [NS*DW-1:0] make_word(input int j);
        logic [NS*DW-1:0] w;
        w = '0;
        for (int l = 0; l < NS; l++) w[(NS - 1 - l) * DW +: DW] = sample_of(j, l);
        return w;
    endfunction

    task automatic expect_sample(input logic [DW-1:0] d, input int l);
        check_eq("m_tvalid", 32'(m_axis_tvalid), 32'd1);
        check_eq("m_tdata", 32'(m_axis_tdata), 32'(d));
        check_eq("m_tstreamno", 32'(m_axis_tstreamno), 32'(1 << l));
        check_eq("m_tchno", 32'(m_axis_tchno), 32'(l * CPS + exp_ch));
        check_eq("m_tlast", 32'(m_axis_tlast), 32'((l == NS - 1) && (exp_ch == CPS - 1)));
        check_eq("frame_cnt", frame_cnt, 32'(exp_frames));
    endtask

    task automatic check_idle(input logic exp_s_ready);
        check_eq("idle_m_tvalid", 32'(m_axis_tvalid), 32'd0);
        check_eq("idle_s_tready", 32'(s_axis_tready), 32'(exp_s_ready));
    endtask

    // Streams n words starting at index j0; optional 3-cycle stall on lane 2 of word stall_w,
    // optional one-cycle reset on lane 3 of word rst_w.
    task automatic run_words(input int n, input int j0, input int stall_w, input int rst_w);
        s_axis_tdata  = make_word(j0);
        s_axis_tvalid = 1'b1;
        for (int w = 0; w < n; w++) begin
            for (int l = 0; l < NS; l++) begin
                @(negedge bus_clk);
                expect_sample(sample_of(j0 + w, l), l);
                check_eq("s_tready_pulse", 32'(s_axis_tready), 32'(l == NS - 1));
                if (w == rst_w && l == 3) begin
                    aresetn       = 1'b0;
                    s_axis_tvalid = 1'b0;
                    @(negedge bus_clk);
                    check_idle(1'b0);
                    check_eq("rst_m_tchno", 32'(m_axis_tchno), 32'd0);
                    check_eq("rst_frame_cnt", frame_cnt, 32'd0);
                    aresetn    = 1'b1;
                    exp_ch     = 0;
                    exp_frames = 0;
                    return;
                end
                if (w == stall_w && l == 2) begin
                    m_axis_tready = 1'b0;
                    repeat (3) begin
                        @(negedge bus_clk);
                        expect_sample(sample_of(j0 + w, l), l);
                        check_eq("stall_s_tready", 32'(s_axis_tready), 32'd0);
                    end
                    m_axis_tready = 1'b1;
                end
                if (l == NS - 1) begin
`ifdef RAW_SPLIT_FRAME_CNT_EN
                    if (exp_ch == CPS - 1) exp_frames++;
`endif
                    exp_ch = (exp_ch + 1) % CPS;
                    if (w < n - 1) s_axis_tdata = make_word(j0 + w + 1);
                    else s_axis_tvalid = 1'b0;
                end
            end
        end
    endtask

    initial begin
        // Reset state
        repeat (3) @(negedge bus_clk);
        check_idle(1'b0);
        check_eq("rst_m_tdata", 32'(m_axis_tdata), 32'd0);
        check_eq("rst_m_tstreamno", 32'(m_axis_tstreamno), 32'd0);
        check_eq("rst_m_tlast", 32'(m_axis_tlast), 32'd0);
        check_eq("rst_frame_cnt", frame_cnt, 32'd0);

        // First word with hand-written lane ordering
        aresetn       = 1'b1;
        s_axis_tdata  = 80'h0001_0002_0003_0004_0005;
        s_axis_tvalid = 1'b1;
        #1;
        check_idle(1'b1);
        for (int l = 0; l < NS; l++) begin
            @(negedge bus_clk);
            if (l == 0) s_axis_tvalid = 1'b0;
            expect_sample(DW'(l + 1), l);
        end
        exp_ch = 1;

        // Input gap: back to EMPTY
        repeat (4) begin
            @(negedge bus_clk);
            check_idle(1'b1);
        end

        // 33 back-to-back words across the frame boundary, stall on lane 2 of word 5
        run_words(33, 16, 5, -1);
        repeat (4) begin
            @(negedge bus_clk);
            check_idle(1'b1);
        end

        // Resume after gap with ch_idx continuing, reach ch_idx 10, reset on lane 3
        run_words(8, 100, -1, -1);
        check_eq("ch_before_reset", 32'(exp_ch), 32'd10);
        run_words(1, 200, -1, 0);

        // After reset the next word restarts at channel 0
        run_words(1, 300, -1, -1);

        // 96 words from ch_idx 1 contain three frame ends
        run_words(96, 400, -1, -1);
        @(negedge bus_clk);
        check_idle(1'b1);
`ifdef RAW_SPLIT_FRAME_CNT_EN
        check_eq("final_frame_cnt", frame_cnt, 32'd3);
`else
        check_eq("final_frame_cnt", frame_cnt, 32'd0);
`endif

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog expired");
    end

endmodule
